frame_config_sequencer: RTL and testbench
=========================================

Name: frame_config_sequencer

Overview:
- Accepts a 32-bit configuration word stream over a valid/ready handshake and sequences frame writes into the per-tile frame latches.
- Assembles one frame of data across all rows and drives the column-wide FrameData bus. Then pulses exactly one FrameStrobe bit, selected by the column and frame index in the frame header.
- Sits between the bitstream source (UART/SPI loader) and the fabric's FrameData/FrameStrobe distribution.

Parameters:
- NumberOfCols, 4, fabric columns addressed (1..256)
- NumberOfRows, 2, tile rows per column; one 32-bit data word per row
- MaxFramesPerCol, 20, frames per column (1..256)
- FrameBitsPerRow, 32, frame bits per row; fixed at 32 (equals stream word width)
- StrobeCycles, 2, FrameStrobe pulse width in cycles (>=1)

Ports:
- CLK  input  1  clock
- resetn  input  1  synchronous active-low reset
- s_data  input  32  config word
- s_valid  input  1  word valid
- s_ready  output  1  block can accept word
- FrameData  output  FrameBitsPerRow*NumberOfRows  frame data; row r occupies bits [32r+31:32r]
- FrameStrobe  output  MaxFramesPerCol*NumberOfCols  one-hot frame write strobe; index col*MaxFramesPerCol+frame
- busy  output  1  high in any state other than IDLE
- err_sync  output  1  sticky: header word with bad sync byte received
- err_addr  output  1  sticky: header column/frame index out of range
- frames_done  output  16  count of strobed frames, wraps modulo 2^16

Behaviour:
- Transfer occurs on a rising CLK edge with s_valid && s_ready.
- Header word format:
  - [31:24] sync byte = 8'hFA
  - [23:16] column index
  - [15:8] frame index
  - [7:0] ignored
- Reset (resetn=0 at an edge): state=IDLE; FrameData=0; FrameStrobe=0; s_ready=0 during reset; busy=0; err_*=0; frames_done=0.
- Reset mid-operation: any active strobe drops at that edge and the partial frame is discarded.
- IDLE: s_ready=1.
  - Header with bad sync: word dropped, err_sync set, stay IDLE.
  - Valid header with col<NumberOfCols and frame<MaxFramesPerCol: latch indices, row counter=0, go LOAD.
  - Valid sync but out-of-range index: set err_addr, go LOAD with the discard flag set.
- LOAD: s_ready=1.
  - Each accepted word is written to FrameData row slice [row counter] at that edge; row counter increments.
  - When discarding, words are consumed but FrameData is unchanged.
  - After row NumberOfRows-1 is accepted: go STROBE, or GAP if discarding (or CHECK when CONFIG_CRC_EN is defined).
- STROBE: s_ready=0.
  - The selected FrameStrobe bit is high for exactly StrobeCycles cycles, starting the edge after the last data word.
  - All other strobe bits stay 0.
  - frames_done increments on entry.
- GAP: s_ready=0 and all strobes 0 for one cycle (hold time), then IDLE.
- FrameData is stable from the last data edge through the end of GAP and keeps its value until overwritten.
- Latency from last data word to strobe rising: 1 cycle. Minimum cycles per frame: 1+NumberOfRows+StrobeCycles+1.
- s_valid low mid-frame: state holds and no timeout applies.
- err_* clear only on reset.

Optional Feature:
- Macro: CONFIG_CRC_EN
- Defined:
  - After the last data word the block enters CHECK (s_ready=1) and accepts one trailer word.
  - The trailer must equal the XOR of the header and all data words of the frame.
  - Match: go STROBE.
  - Mismatch: set sticky output err_crc (extra 1-bit port, reset 0), suppress the strobe, do not increment frames_done, go GAP.
  - Discarded frames also consume the trailer.
- Not defined: no trailer word, no err_crc port, and the last data word leads directly to STROBE.

Test Plan:
- Header 32'hFA01_0300, data 32'hDEAD_BEEF, 32'h1234_5678, s_valid held high -> FrameData=64'h1234_5678_DEAD_BEEF; FrameStrobe bit 23 high for exactly 2 cycles starting 1 cycle after the 2nd data word; s_ready low 3 cycles; frames_done=1.
- Header 32'h5501_0300 -> err_sync=1, state IDLE, next valid header processed normally.
- Header 32'hFA04_0000 (col 4) plus 2 data words -> err_addr=1, words consumed, FrameStrobe stays 0, FrameData unchanged, frames_done unchanged.
- Valid header, s_valid toggled 0/1 between data words -> frame completes correctly; back-to-back second frame (col 3, frame 19) -> strobe bit 79 only.
- resetn asserted during STROBE cycle 1 -> FrameStrobe=0 at that edge, FrameData=0, frames_done=0, s_ready=1 after release.
- With CONFIG_CRC_EN, trailer = XOR of the three words -> strobe fires; trailer off by 1 bit -> err_crc=1, no strobe.

Source files
------------

// File: rtl/frame_config_sequencer.sv
// Frame configuration sequencer: assembles header + per-row data words into FrameData and pulses one FrameStrobe bit.
// Optional trailer checksum stage is enabled by defining CONFIG_CRC_EN (adds err_crc output).
module frame_config_sequencer #(
    parameter int NumberOfCols    = 4,
    parameter int NumberOfRows    = 2,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int StrobeCycles    = 2
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [31:0]                             s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
    output logic [MaxFramesPerCol*NumberOfCols-1:0] FrameStrobe,
    output logic                                    busy,
    output logic                                    err_sync,
    output logic                                    err_addr,
`ifdef CONFIG_CRC_EN
    output logic                                    err_crc,
`endif
    output logic [15:0]                             frames_done
);

    localparam int DATA_W   = FrameBitsPerRow * NumberOfRows;
    localparam int STROBE_W = MaxFramesPerCol * NumberOfCols;
    localparam int ROW_W    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int SCNT_W   = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [7:0] SYNC_BYTE = 8'hFA;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_STROBE, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [7:0]          col_q, col_d;
    logic [7:0]          frame_q, frame_d;
    logic                discard_q, discard_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [STROBE_W-1:0] strobe_q, strobe_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [15:0]         done_q, done_d;
    logic                err_sync_q, err_sync_d;
    logic                err_addr_q, err_addr_d;
`ifdef CONFIG_CRC_EN
    logic [31:0]         crc_q, crc_d;
    logic                err_crc_q, err_crc_d;
`endif

    logic        accept;
    logic        hdr_in_range;
    logic        last_row;
    logic        go_strobe;
    logic [31:0] strobe_idx;

    assign s_ready = resetn && (state_q == S_IDLE || state_q == S_LOAD || state_q == S_CHECK);
    assign accept  = s_valid && s_ready;
    assign hdr_in_range = (32'(s_data[23:16]) < NumberOfCols) && (32'(s_data[15:8]) < MaxFramesPerCol);
    assign last_row     = (row_q == ROW_W'(NumberOfRows - 1));
    assign strobe_idx   = 32'(col_q) * 32'(MaxFramesPerCol) + 32'(frame_q);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        frame_d    = frame_q;
        discard_d  = discard_q;
        data_d     = data_q;
        strobe_d   = strobe_q;
        scnt_d     = scnt_q;
        done_d     = done_q;
        err_sync_d = err_sync_q;
        err_addr_d = err_addr_q;
        go_strobe  = 1'b0;
`ifdef CONFIG_CRC_EN
        crc_d      = crc_q;
        err_crc_d  = err_crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (s_data[31:24] != SYNC_BYTE) begin
                        err_sync_d = 1'b1;
                    end else begin
                        col_d     = s_data[23:16];
                        frame_d   = s_data[15:8];
                        row_d     = '0;
                        discard_d = !hdr_in_range;
                        state_d   = S_LOAD;
                        if (!hdr_in_range) err_addr_d = 1'b1;
`ifdef CONFIG_CRC_EN
                        crc_d = s_data;
`endif
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (!discard_q) data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    row_d = row_q + 1'b1;
`ifdef CONFIG_CRC_EN
                    crc_d = crc_q ^ s_data;
                    if (last_row) state_d = S_CHECK;
`else
                    if (last_row) begin
                        if (discard_q) state_d = S_GAP;
                        else           go_strobe = 1'b1;
                    end
`endif
                end
            end
`ifdef CONFIG_CRC_EN
            S_CHECK: begin
                if (accept) begin
                    if (discard_q) begin
                        state_d = S_GAP;
                    end else if (s_data == crc_q) begin
                        go_strobe = 1'b1;
                    end else begin
                        err_crc_d = 1'b1;
                        state_d   = S_GAP;
                    end
                end
            end
`endif
            S_STROBE: begin
                scnt_d = scnt_q + 1'b1;
                if (scnt_q == SCNT_W'(StrobeCycles - 1)) begin
                    strobe_d = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobe is registered so it rises exactly one edge after the word that completes the frame.
        if (go_strobe) begin
            state_d  = S_STROBE;
            strobe_d = STROBE_W'(1) << strobe_idx;
            scnt_d   = '0;
            done_d   = done_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            frame_q    <= '0;
            discard_q  <= 1'b0;
            data_q     <= '0;
            strobe_q   <= '0;
            scnt_q     <= '0;
            done_q     <= '0;
            err_sync_q <= 1'b0;
            err_addr_q <= 1'b0;
`ifdef CONFIG_CRC_EN
            crc_q      <= '0;
            err_crc_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            frame_q    <= frame_d;
            discard_q  <= discard_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            scnt_q     <= scnt_d;
            done_q     <= done_d;
            err_sync_q <= err_sync_d;
            err_addr_q <= err_addr_d;
`ifdef CONFIG_CRC_EN
            crc_q      <= crc_d;
            err_crc_q  <= err_crc_d;
`endif
        end
    end

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = (state_q != S_IDLE);
    assign err_sync    = err_sync_q;
    assign err_addr    = err_addr_q;
    assign frames_done = done_q;
`ifdef CONFIG_CRC_EN
    assign err_crc     = err_crc_q;
`endif

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Self-checking bench for frame_config_sequencer: directed scenarios plus randomized frames against an array/counter model.
module tb_frame_config_sequencer;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int MFPC = 20;
    localparam int SC   = 2;
    localparam int DW   = 32 * ROWS;
    localparam int SW   = MFPC * COLS;
`ifdef CONFIG_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          resetn;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] FrameData;
    logic [SW-1:0] FrameStrobe;
    logic          busy;
    logic          err_sync;
    logic          err_addr;
    logic [15:0]   frames_done;
`ifdef CONFIG_CRC_EN
    logic          err_crc;
    logic          model_err_crc;
`endif

    // Reference model state
    logic [DW-1:0] model_data;
    logic [15:0]   model_done;
    logic          model_err_sync;
    logic          model_err_addr;
    logic [31:0]   frame_words [ROWS];

    int n_cmp = 0;
    int n_mis = 0;

    frame_config_sequencer #(
        .NumberOfCols(COLS), .NumberOfRows(ROWS), .MaxFramesPerCol(MFPC),
        .FrameBitsPerRow(32), .StrobeCycles(SC)
    ) dut (
        .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy),
        .err_sync(err_sync), .err_addr(err_addr),
`ifdef CONFIG_CRC_EN
        .err_crc(err_crc),
`endif
        .frames_done(frames_done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        model_data     = '0;
        model_done     = '0;
        model_err_sync = 1'b0;
        model_err_addr = 1'b0;
`ifdef CONFIG_CRC_EN
        model_err_crc  = 1'b0;
`endif
    endtask

    // Present one word, optionally after random idle cycles; returns once it has been accepted.
    task automatic push(input logic [31:0] w, input int gap_max);
        int g;
        int budget;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        s_valid = 1'b0;
        repeat (g) step();
        s_valid = 1'b1;
        s_data  = w;
        budget  = 0;
        while (!s_ready && budget < 50) begin
            step();
            budget++;
        end
        n_cmp++;
        if (!s_ready) begin
            n_mis++;
            $display("FAIL push_timeout: s_ready got %b required 1 for word %h", s_ready, w);
        end else begin
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        n_cmp++;
        if (FrameData !== model_data) begin
            n_mis++;
            $display("FAIL %s_framedata: got %h required %h", tag, FrameData, model_data);
        end
        n_cmp++;
        if (frames_done !== model_done) begin
            n_mis++;
            $display("FAIL %s_frames_done: got %0d required %0d", tag, frames_done, model_done);
        end
        n_cmp++;
        if (err_sync !== model_err_sync || err_addr !== model_err_addr) begin
            n_mis++;
            $display("FAIL %s_err: got sync=%b addr=%b required sync=%b addr=%b", tag, err_sync, err_addr, model_err_sync, model_err_addr);
        end
`ifdef CONFIG_CRC_EN
        n_cmp++;
        if (err_crc !== model_err_crc) begin
            n_mis++;
            $display("FAIL %s_err_crc: got %b required %b", tag, err_crc, model_err_crc);
        end
`endif
    endtask

    // Drive one header + data (+ trailer) and check the strobe/ready timeline and resulting state.
    task automatic run_frame(input logic [31:0] hdr, input int gap_max, input bit bad_trailer, input string tag);
        logic [31:0] x;
        logic [SW-1:0] exp_s;
        int col;
        int frm;
        bit in_range;
        bit fires;
        col = int'(hdr[23:16]);
        frm = int'(hdr[15:8]);
        in_range = (col < COLS) && (frm < MFPC);
        fires = in_range && !(CRC_EN && bad_trailer);
        exp_s = '0;
        if (fires) exp_s[col * MFPC + frm] = 1'b1;

        push(hdr, gap_max);
        x = hdr;
        for (int r = 0; r < ROWS; r++) begin
            push(frame_words[r], gap_max);
            x = x ^ frame_words[r];
        end
        if (CRC_EN) push(bad_trailer ? (x ^ 32'h0000_0100) : x, gap_max);

        if (in_range) begin
            for (int r = 0; r < ROWS; r++) model_data[r*32 +: 32] = frame_words[r];
        end
        if (fires) model_done = model_done + 16'd1;
        if (!in_range) model_err_addr = 1'b1;
`ifdef CONFIG_CRC_EN
        if (in_range && bad_trailer) model_err_crc = 1'b1;
`endif

        if (fires) begin
            for (int k = 0; k < SC; k++) begin
                n_cmp++;
                if (FrameStrobe !== exp_s || s_ready !== 1'b0) begin
                    n_mis++;
                    $display("FAIL %s_strobe_c%0d: got strobe=%h rdy=%b required strobe=%h rdy=0", tag, k, FrameStrobe, s_ready, exp_s);
                end
                step();
            end
        end
        n_cmp++;
        if (FrameStrobe !== '0 || s_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL %s_gap: got strobe=%h rdy=%b required strobe=0 rdy=0", tag, FrameStrobe, s_ready);
        end
        step();
        n_cmp++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || FrameStrobe !== '0) begin
            n_mis++;
            $display("FAIL %s_idle: got rdy=%b busy=%b strobe=%h required rdy=1 busy=0 strobe=0", tag, s_ready, busy, FrameStrobe);
        end
        check_state(tag);
        $display("frame %s hdr=%h fires=%0d frames_done=%0d", tag, hdr, fires, frames_done);
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        model_reset();
        repeat (2) step();
        n_cmp++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || FrameStrobe !== '0) begin
            n_mis++;
            $display("FAIL reset_ctrl: got rdy=%b busy=%b strobe=%h required 0/0/0", s_ready, busy, FrameStrobe);
        end
        check_state("reset");
        resetn = 1'b1;
        step();
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_release_rdy: got %b required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        frame_words[0] = 32'hDEAD_BEEF;
        frame_words[1] = 32'h1234_5678;
        run_frame(32'hFA01_0300, 0, 1'b0, "basic");
        n_cmp++;
        if (FrameData !== 64'h1234_5678_DEAD_BEEF || frames_done !== 16'd1) begin
            n_mis++;
            $display("FAIL basic_const: got data=%h done=%0d required 1234_5678_dead_beef/1", FrameData, frames_done);
        end
    endtask

    task automatic test_bad_sync();
        push(32'h5501_0300, 0);
        model_err_sync = 1'b1;
        n_cmp++;
        if (err_sync !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL bad_sync: got err=%b busy=%b rdy=%b required 1/0/1", err_sync, busy, s_ready);
        end
        frame_words[0] = 32'hA5A5_0001;
        frame_words[1] = 32'h5A5A_0002;
        run_frame(32'hFA02_0500, 0, 1'b0, "after_sync");
    endtask

    task automatic test_bad_addr();
        frame_words[0] = 32'hFFFF_0000;
        frame_words[1] = 32'h0000_FFFF;
        run_frame(32'hFA04_0000, 0, 1'b0, "bad_col");
        frame_words[0] = 32'h1111_1111;
        run_frame(32'hFA00_1400, 1, 1'b0, "bad_frame");
    endtask

    task automatic test_back_to_back();
        frame_words[0] = 32'hCAFE_0001;
        frame_words[1] = 32'hCAFE_0002;
        run_frame(32'hFA00_0000, 2, 1'b0, "gaps");
        frame_words[0] = 32'hBEEF_0003;
        frame_words[1] = 32'hBEEF_0004;
        run_frame(32'hFA03_1300, 0, 1'b0, "last_bit");
    endtask

`ifdef CONFIG_CRC_EN
    task automatic test_crc();
        frame_words[0] = 32'h0F0F_0F0F;
        frame_words[1] = 32'h3333_CCCC;
        run_frame(32'hFA01_0200, 0, 1'b0, "crc_good");
        frame_words[0] = 32'h7777_0000;
        run_frame(32'hFA01_0200, 0, 1'b1, "crc_bad");
    endtask
`endif

    task automatic test_random();
        logic [31:0] hdr;
        logic [7:0]  sb;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sb = 8'($urandom_range(0, 255));
                if (sb == 8'hFA) sb = 8'h00;
                push({sb, 24'($urandom)}, 1);
                model_err_sync = 1'b1;
            end
            hdr = {8'hFA, 8'($urandom_range(0, COLS)), 8'($urandom_range(0, MFPC)), 8'($urandom)};
            for (int r = 0; r < ROWS; r++) frame_words[r] = $urandom;
            run_frame(hdr, $urandom_range(0, 2), CRC_EN && ($urandom_range(0, 4) == 0), "rand");
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hdr;
        hdr = 32'hFA02_0100;
        frame_words[0] = 32'h0123_4567;
        frame_words[1] = 32'h89AB_CDEF;
        push(hdr, 0);
        push(frame_words[0], 0);
        push(frame_words[1], 0);
        if (CRC_EN) push(hdr ^ frame_words[0] ^ frame_words[1], 0);
        n_cmp++;
        if (FrameStrobe[2*MFPC + 1] !== 1'b1) begin
            n_mis++;
            $display("FAIL mid_strobe_on: got %b required 1", FrameStrobe[2*MFPC + 1]);
        end
        resetn = 1'b0;
        step();
        model_reset();
        n_cmp++;
        if (FrameStrobe !== '0 || s_ready !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL mid_reset: got strobe=%h rdy=%b busy=%b required 0/0/0", FrameStrobe, s_ready, busy);
        end
        check_state("mid_reset");
        resetn = 1'b1;
        step();
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL mid_release_rdy: got %b required 1", s_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_sync();
        test_bad_addr();
        test_back_to_back();
`ifdef CONFIG_CRC_EN
        test_crc();
`endif
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
